qmul_rr_scheduler: RTL and testbench



---
 rtl/qformat_pkg.sv | 40 ++++
 rtl/qmul_scale_sat.sv | 42 ++++
 rtl/qmul_rr_scheduler.sv | 117 +++++++++++
 tb/tb_qmul_rr_scheduler.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/qformat_pkg.sv
// Shared Q1.F format constants, helper functions and the scheduler FSM encoding.
// Functions take the fractional-bit count so parameterised modules derive their own widths.
package qformat_pkg;

  localparam int NUM_FIXED_BITS_DEFAULT = 8;

  function automatic int q_w(input int f);
    return f + 1;
  endfunction

  function automatic int q_prod_w(input int f);
    return 2 * (f + 1);
  endfunction

  function automatic int q_max(input int f);
    return (1 << f) - 1;
  endfunction

  function automatic int q_min(input int f);
    return -(1 << f);
  endfunction

  function automatic int q_round_bias(input int f);
    return 1 << (f - 1);
  endfunction

  localparam int W          = q_w(NUM_FIXED_BITS_DEFAULT);
  localparam int PROD_W     = q_prod_w(NUM_FIXED_BITS_DEFAULT);
  localparam int QMAX       = q_max(NUM_FIXED_BITS_DEFAULT);
  localparam int QMIN       = q_min(NUM_FIXED_BITS_DEFAULT);
  localparam int ROUND_BIAS = q_round_bias(NUM_FIXED_BITS_DEFAULT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_SCALE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/qmul_scale_sat.sv
// Combinational Q2.2F -> Q1.F rescale with saturation and a clip flag.
// Build option QMUL_ROUND_NEAREST_EN: round half toward +inf; otherwise truncate toward -inf.
module qmul_scale_sat #(
  parameter int NUM_FIXED_BITS = 8
) (
  input  logic signed [2*NUM_FIXED_BITS+1:0] product,
  output logic signed [NUM_FIXED_BITS:0]     result,
  output logic                               sat
);
  import qformat_pkg::*;

  localparam int DW = q_w(NUM_FIXED_BITS);
  localparam int PW = q_prod_w(NUM_FIXED_BITS);
  // One guard bit so the rounding bias can never wrap the sign.
  localparam int EW = PW + 1;
  localparam logic signed [EW-1:0] SMAX = EW'(q_max(NUM_FIXED_BITS));
  localparam logic signed [EW-1:0] SMIN = EW'(q_min(NUM_FIXED_BITS));

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] biased;
  logic signed [EW-1:0] shifted;

  always_comb begin
    ext = EW'(product);
`ifdef QMUL_ROUND_NEAREST_EN
    biased = ext + EW'(q_round_bias(NUM_FIXED_BITS));
`else
    biased = ext;
`endif
    shifted = biased >>> NUM_FIXED_BITS;
    result  = shifted[DW-1:0];
    sat     = 1'b0;
    if (shifted > SMAX) begin
      result = SMAX[DW-1:0];
      sat    = 1'b1;
    end else if (shifted < SMIN) begin
      result = SMIN[DW-1:0];
      sat    = 1'b1;
    end
  end

endmodule

// File: rtl/qmul_rr_scheduler.sv
// Round-robin scheduler sharing one signed Q1.F multiplier among NUM_REQ requesters.
// Rounding mode selected by QMUL_ROUND_NEAREST_EN (see qmul_scale_sat).
module qmul_rr_scheduler #(
  parameter int NUM_FIXED_BITS = 8,
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_REQ-1:0]                      req_valid,
  output logic [NUM_REQ-1:0]                      req_ready,
  input  logic [NUM_REQ*(NUM_FIXED_BITS+1)-1:0]   req_a,
  input  logic [NUM_REQ*(NUM_FIXED_BITS+1)-1:0]   req_b,
  output logic                                    resp_valid,
  input  logic                                    resp_ready,
  output logic signed [NUM_FIXED_BITS:0]          resp_data,
  output logic [ID_W-1:0]                         resp_id,
  output logic                                    resp_sat,
  output logic                                    busy
);
  import qformat_pkg::*;

  localparam int DW = q_w(NUM_FIXED_BITS);
  localparam int PW = q_prod_w(NUM_FIXED_BITS);

  state_t                state_reg, state_next;
  logic [ID_W-1:0]       rr_ptr_reg;
  logic signed [DW-1:0]  a_reg, b_reg;
  logic [ID_W-1:0]       id_reg;
  logic signed [PW-1:0]  product_reg;
  logic signed [DW-1:0]  resp_data_reg;
  logic [ID_W-1:0]       resp_id_reg;
  logic                  resp_sat_reg;

  logic signed [DW-1:0]  req_a_arr [NUM_REQ];
  logic signed [DW-1:0]  req_b_arr [NUM_REQ];
  logic                  grant_found;
  logic [ID_W-1:0]       grant_idx;
  logic signed [DW-1:0]  scaled;
  logic                  scaled_sat;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_a_arr[gi] = req_a[gi*DW +: DW];
    assign req_b_arr[gi] = req_b[gi*DW +: DW];
    assign req_ready[gi] = (state_reg == ST_IDLE) && grant_found && (grant_idx == ID_W'(gi));
  end

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && req_valid[(int'(rr_ptr_reg) + k) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (grant_found) state_next = ST_MUL;
      ST_MUL:   state_next = ST_SCALE;
      ST_SCALE: state_next = ST_RESP;
      ST_RESP:  if (resp_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  qmul_scale_sat #(
    .NUM_FIXED_BITS(NUM_FIXED_BITS)
  ) u_scale (
    .product(product_reg),
    .result (scaled),
    .sat    (scaled_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      rr_ptr_reg    <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      id_reg        <= '0;
      product_reg   <= '0;
      resp_data_reg <= '0;
      resp_id_reg   <= '0;
      resp_sat_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: if (grant_found) begin
          a_reg      <= req_a_arr[grant_idx];
          b_reg      <= req_b_arr[grant_idx];
          id_reg     <= grant_idx;
          rr_ptr_reg <= ID_W'((int'(grant_idx) + 1) % NUM_REQ);
        end
        ST_MUL:   product_reg <= PW'(a_reg) * PW'(b_reg);
        ST_SCALE: begin
          resp_data_reg <= scaled;
          resp_sat_reg  <= scaled_sat;
          resp_id_reg   <= id_reg;
        end
        default: ;
      endcase
    end
  end

  // resp_valid is exactly "in RESP", so it is registered via the state.
  assign resp_valid = (state_reg == ST_RESP);
  assign busy       = (state_reg != ST_IDLE);
  assign resp_data  = resp_data_reg;
  assign resp_id    = resp_id_reg;
  assign resp_sat   = resp_sat_reg;

endmodule

// File: tb/tb_qmul_rr_scheduler.sv
// Directed bench for qmul_rr_scheduler (F=8, 4 requesters); expectations hand-computed.
// Rounding expectations follow QMUL_ROUND_NEAREST_EN when the bench is built with it.
module tb_qmul_rr_scheduler;
  localparam int F  = 8;
  localparam int W  = F + 1;
  localparam int N  = 4;
  localparam int IW = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [N*W-1:0]      req_a, req_b;
  logic                resp_valid;
  logic                resp_ready;
  logic signed [W-1:0] resp_data;
  logic [IW-1:0]       resp_id;
  logic                resp_sat;
  logic                busy;

  logic signed [W-1:0] opa [N];
  logic signed [W-1:0] opb [N];

  int total  = 0;
  int passed = 0;
  int failed = 0;

  assign req_a = {opa[3], opa[2], opa[1], opa[0]};
  assign req_b = {opb[3], opb[2], opb[1], opb[0]};

  always #5 clk = ~clk;

  qmul_rr_scheduler #(
    .NUM_FIXED_BITS(F),
    .NUM_REQ       (N),
    .ID_W          (IW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_id   (resp_id),
    .resp_sat  (resp_sat),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller has set operands/valid while IDLE; runs one job with resp_ready high.
  task automatic do_job(input int id, input int data, input int sat, input bit drop, input string tag);
    #1;
    chk({tag, ".ready"}, 32'(req_ready), 1 << id);
    tick();
    if (drop) req_valid = '0;
    chk({tag, ".busy_mul"}, 32'(busy), 1);
    chk({tag, ".valid_mul"}, 32'(resp_valid), 0);
    tick();
    chk({tag, ".valid_scale"}, 32'(resp_valid), 0);
    tick();
    chk({tag, ".valid"}, 32'(resp_valid), 1);
    chk({tag, ".data"}, 32'(resp_data), data);
    chk({tag, ".id"}, 32'(resp_id), id);
    chk({tag, ".sat"}, 32'(resp_sat), sat);
    tick();
    chk({tag, ".valid_done"}, 32'(resp_valid), 0);
    $display("job %s: id=%0d data=%0d sat=%0d", tag, resp_id, resp_data, resp_sat);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end
    repeat (3) tick();
    chk("rst.resp_valid", 32'(resp_valid), 0);
    chk("rst.resp_data", 32'(resp_data), 0);
    chk("rst.resp_id", 32'(resp_id), 0);
    chk("rst.resp_sat", 32'(resp_sat), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.req_ready", 32'(req_ready), 0);
    rst_n = 1'b1;
    tick();

    // 0.5 * 0.5 = 0.25
    opa[0] = 9'sd128; opb[0] = 9'sd128; req_valid = 4'b0001;
    do_job(0, 64, 0, 1'b1, "half_sq");

    // (-1)*(-1) is the only overflow
    opa[1] = -9'sd256; opb[1] = -9'sd256; req_valid = 4'b0010;
    do_job(1, 255, 1, 1'b1, "neg1_sq");
    opa[2] = -9'sd256; opb[2] = 9'sd255; req_valid = 4'b0100;
    do_job(2, -255, 0, 1'b1, "neg1_x_max");

`ifdef QMUL_ROUND_NEAREST_EN
    opa[3] = 9'sd1; opb[3] = 9'sd128; req_valid = 4'b1000;
    do_job(3, 1, 0, 1'b1, "rnd_pos");
    opa[3] = -9'sd1; opb[3] = 9'sd128; req_valid = 4'b1000;
    do_job(3, 0, 0, 1'b1, "rnd_neg");
`else
    opa[3] = 9'sd1; opb[3] = 9'sd128; req_valid = 4'b1000;
    do_job(3, 0, 0, 1'b1, "trunc_pos");
    opa[3] = -9'sd1; opb[3] = 9'sd128; req_valid = 4'b1000;
    do_job(3, -1, 0, 1'b1, "trunc_neg");
`endif

    // Pointer is back at 0; requester i multiplies (i+1)*10 by -1.0.
    for (int i = 0; i < N; i++) begin
      opa[i] = W'((i + 1) * 10);
      opb[i] = -9'sd256;
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++)
      do_job(k % 4, -((k % 4) + 1) * 10, 0, 1'b0, "rr_all");
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++)
      do_job((k % 2 == 0) ? 1 : 3, (k % 2 == 0) ? -20 : -40, 0, 1'b0, "rr_1_3");
    req_valid = '0;

    // Backpressure
    opa[2] = 9'sd64; opb[2] = 9'sd64; req_valid = 4'b0100; resp_ready = 1'b0;
    #1;
    chk("bp.ready", 32'(req_ready), 4);
    tick();
    req_valid = 4'b1011;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp.hold_valid", 32'(resp_valid), 1);
      chk("bp.hold_data", 32'(resp_data), 16);
      chk("bp.hold_ready", 32'(req_ready), 0);
      chk("bp.hold_busy", 32'(busy), 1);
      tick();
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    #1;
    chk("bp.release_valid", 32'(resp_valid), 1);
    tick();
    chk("bp.after_valid", 32'(resp_valid), 0);
    chk("bp.after_busy", 32'(busy), 0);
    tick();
    chk("bp.idle_valid", 32'(resp_valid), 0);
    chk("bp.idle_busy", 32'(busy), 0);
    $display("job backpressure: data=16 released");

    // Reset in SCALE: job discarded, pointer back to 0
    opa[1] = 9'sd100; opb[1] = 9'sd100; req_valid = 4'b0010;
    #1;
    chk("mid.ready", 32'(req_ready), 2);
    tick();
    req_valid = '0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid.rst_valid", 32'(resp_valid), 0);
    chk("mid.rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("mid.no_stale", 32'(resp_valid), 0);
    chk("mid.idle_busy", 32'(busy), 0);
    req_valid = 4'b1111;
    do_job(0, -10, 0, 1'b1, "post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
